// File: rtl/accum12_stream.sv
// Streaming block accumulator: sums 1..16 unsigned 12-bit samples per block and
// emits the sum plus a sticky carry flag, holding the result until it is taken.

module rca12 (
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic        cin,
  output logic [11:0] sum,
  output logic        cout
);
  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < 12; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end
endmodule

// Handshake: a beat moves on a rising edge only when valid and ready are both 1.
// in_ready depends on state only; out_valid is exactly the HOLD state.
module accum12_stream #(
  parameter bit SAT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [3:0]  len,
  input  logic        in_valid,
  input  logic [11:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [11:0] out_sum,
  output logic        out_ovf,
  input  logic        out_ready
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t      state, state_nxt;
  logic [11:0] acc, acc_nxt;
  logic        ovf, ovf_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  lenq, lenq_nxt;
  logic [11:0] add_sum;
  logic        add_cout;
  logic        accept;
  logic [3:0]  cnt_inc;

  rca12 u_add (
    .a    (acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign accept  = in_valid & in_ready;
  assign cnt_inc = cnt + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
      lenq  <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      ovf   <= ovf_nxt;
      cnt   <= cnt_nxt;
      lenq  <= lenq_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    cnt_nxt   = cnt;
    lenq_nxt  = lenq;
    // clr wins over any acceptance or output handshake in the same cycle
    if (clr) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      ovf_nxt   = 1'b0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_nxt   = in_data;
            ovf_nxt   = 1'b0;
            cnt_nxt   = '0;
            lenq_nxt  = len;
            state_nxt = (len == 4'd0) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            // a saturated acc can only carry again, so it stays pinned at FFF
            acc_nxt = (SAT_EN && add_cout) ? 12'hFFF : add_sum;
            ovf_nxt = ovf | add_cout;
            cnt_nxt = cnt_inc;
            if (cnt_inc == lenq) state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign out_sum   = acc;
  assign out_ovf   = ovf;
endmodule

// File: tb/tb_accum12_stream.sv
// Bench for accum12_stream: saturating and wrapping instances share one stimulus
// stream; a reference model fills expected queues that a monitor drains.

module tb_accum12_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        s_in_ready, s_out_valid, s_out_ovf;
  logic [11:0] s_out_sum;
  logic        w_in_ready, w_out_valid, w_out_ovf;
  logic [11:0] w_out_sum;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  logic [12:0] exp_s_q[$];
  logic [12:0] exp_w_q[$];
  logic [11:0] blk[16];

  accum12_stream #(.SAT_EN(1'b1)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_sum(s_out_sum), .out_ovf(s_out_ovf),
    .out_ready(out_ready)
  );

  accum12_stream #(.SAT_EN(1'b0)) dut_w (
    .clk(clk), .rst(rst), .clr(clr), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(w_in_ready),
    .out_valid(w_out_valid), .out_sum(w_out_sum), .out_ovf(w_out_ovf),
    .out_ready(out_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // drivers: called on a falling edge, return on the falling edge after acceptance
  task automatic send_sample(input logic [11:0] d, input logic [3:0] l, input bit bub);
    int guard;
    if (bub) repeat ($urandom_range(0, 2)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    len      = l;
    guard    = 0;
    while (!(s_in_ready && w_in_ready) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 12'($urandom);
    len      = 4'($urandom);
  endtask

  task automatic run_block(input logic [3:0] l, input bit bub);
    logic [12:0] s;
    logic [11:0] acc_s, acc_w;
    logic        ovf;
    acc_s = blk[0];
    acc_w = blk[0];
    ovf   = 1'b0;
    for (int i = 1; i <= int'(l); i++) begin
      s     = {1'b0, acc_s} + {1'b0, blk[i]};
      acc_s = s[12] ? 12'hFFF : s[11:0];
      s     = {1'b0, acc_w} + {1'b0, blk[i]};
      acc_w = s[11:0];
      ovf   = ovf | s[12];
    end
    exp_s_q.push_back({ovf, acc_s});
    exp_w_q.push_back({ovf, acc_w});
    // len is re-randomised after the first sample; it must be ignored mid-block
    for (int i = 0; i <= int'(l); i++)
      send_sample(blk[i], (i == 0) ? l : 4'($urandom), bub);
  endtask

  // scoreboard monitor: compares held results, randomly back-pressures
  always @(negedge clk) begin
    bit rdy;
    if (mon_en) begin
      rdy = ($urandom_range(0, 2) == 0);
      if (s_out_valid) begin
        check("w_out_valid", {31'd0, w_out_valid}, 32'd1);
        if (exp_s_q.size() == 0 || exp_w_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          check("sat_result", {19'd0, s_out_ovf, s_out_sum}, {19'd0, exp_s_q[0]});
          check("wrap_result", {19'd0, w_out_ovf, w_out_sum}, {19'd0, exp_w_q[0]});
          if (rdy) begin
            void'(exp_s_q.pop_front());
            void'(exp_w_q.pop_front());
          end
        end
      end
      out_ready = rdy;
    end
  end

  initial begin
    int guard;
    #2;
    check("rst_in_ready", {31'd0, s_in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, s_out_valid}, 32'd0);
    check("rst_out_sum", {20'd0, s_out_sum}, 32'd0);
    check("rst_out_ovf", {31'd0, s_out_ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single-sample block, latency 1, held under back-pressure
    send_sample(12'h123, 4'd0, 1'b0);
    check("single_valid", {31'd0, s_out_valid}, 32'd1);
    check("single_sum", {20'd0, s_out_sum}, 32'h123);
    check("single_ovf", {31'd0, s_out_ovf}, 32'd0);
    check("single_in_ready", {31'd0, s_in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    check("single_hold_valid", {31'd0, s_out_valid}, 32'd1);
    check("single_hold_sum", {20'd0, s_out_sum}, 32'h123);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("single_drain_valid", {31'd0, s_out_valid}, 32'd0);
    check("single_drain_in_ready", {31'd0, s_in_ready}, 32'd1);

    // abort with clr on the 3rd sample of a len=7 block
    send_sample(12'h010, 4'd7, 1'b0);
    send_sample(12'h020, 4'd0, 1'b0);
    in_valid = 1'b1;
    in_data  = 12'h030;
    clr      = 1'b1;
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    check("abort_in_ready", {31'd0, s_in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, s_out_valid}, 32'd0);
    check("abort_sum_cleared", {20'd0, s_out_sum}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_result", {31'd0, s_out_valid}, 32'd0);
    send_sample(12'h005, 4'd0, 1'b0);
    check("after_abort_valid", {31'd0, s_out_valid}, 32'd1);
    check("after_abort_sum", {19'd0, s_out_ovf, s_out_sum}, 32'h005);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // directed blocks through the scoreboard
    mon_en = 1'b1;
    blk[0] = 12'd1; blk[1] = 12'd2; blk[2] = 12'd3; blk[3] = 12'd4;
    run_block(4'd3, 1'b1);
    blk[0] = 12'hFFE; blk[1] = 12'h003; blk[2] = 12'h000;
    run_block(4'd2, 1'b0);
    blk[0] = 12'h800; blk[1] = 12'h801;
    run_block(4'd1, 1'b0);

    // random blocks
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < 16; i++)
        blk[i] = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(12'hE00, 12'hFFF))
                                             : 12'($urandom_range(0, 12'h3FF));
      run_block(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    guard = 0;
    while ((exp_s_q.size() != 0) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", exp_s_q.size(), 32'd0);
    mon_en    = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    // asynchronous reset while a result is held
    send_sample(12'h0AB, 4'd0, 1'b0);
    check("pre_rst_valid", {31'd0, s_out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, s_out_valid}, 32'd0);
    check("async_rst_in_ready", {31'd0, s_in_ready}, 32'd1);
    check("async_rst_sum", {19'd0, s_out_ovf, s_out_sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_sample(12'h00A, 4'd0, 1'b0);
    check("post_rst_block", {19'd0, s_out_ovf, s_out_sum}, 32'h00A);
    check("post_rst_valid", {31'd0, s_out_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
